irq_controller: RTL and testbench



---
 rtl/irq_pkg.sv | 18 +
 rtl/irq_controller_if.sv | 27 ++
 rtl/irq_timer.sv | 33 +++
 rtl/irq_controller.sv | 120 ++++++++++++
 tb/tb_irq_controller.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared state encoding, source ids and widths for the interrupt controller
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        SERVICE = 2'd2
    } state_t;

    localparam int NSRC   = 4;
    localparam int ADDR_W = 10;

    localparam logic [1:0] ID_EXCEPT  = 2'd0;
    localparam logic [1:0] ID_SYSCALL = 2'd1;
    localparam logic [1:0] ID_PORT    = 2'd2;
    localparam logic [1:0] ID_TIMER   = 2'd3;

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - request/vector bundle between interrupt sources, control unit and irq_controller
interface irq_controller_if;
    import irq_pkg::*;

    logic              i_except;
    logic              i_syscall;
    logic              i_port;
    logic              timer_en;
    logic              ie;
    logic              s_finished;
    logic [ADDR_W-1:0] dir_vector;
    logic              s_interruption;
    logic              in_service;
    logic [1:0]        active_id;
    logic [NSRC-1:0]   irq_pending;

    modport master (
        output i_except, i_syscall, i_port, timer_en, ie, s_finished,
        input  dir_vector, s_interruption, in_service, active_id, irq_pending
    );

    modport slave (
        input  i_except, i_syscall, i_port, timer_en, ie, s_finished,
        output dir_vector, s_interruption, in_service, active_id, irq_pending
    );

endinterface

// File: rtl/irq_timer.sv
// rtl/irq_timer.sv - free-running period counter; tick is high in the cycle the count wraps
module irq_timer #(
    parameter int TIMER_PERIOD = 1000,
    parameter int TW           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    assign tick = en && (count_q == TW'(TIMER_PERIOD - 1));

    // Disabling the timer restarts the period rather than freezing it.
    always_comb begin
        count_d = count_q + 1'b1;
        if (!en || tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge capture, fixed-priority take and vector generation for four sources
// Optional build macro IRQ_TIMER_EN adds the internal periodic timer as source 3.
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] VEC_BASE     = 10'h3C0,
    parameter int                VEC_STRIDE   = 16,
    parameter int                TIMER_PERIOD = 1000,
    parameter int                TW           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_except,
    input  logic              i_syscall,
    input  logic              i_port,
    input  logic              timer_en,
    input  logic              ie,
    input  logic              s_finished,
    output logic [ADDR_W-1:0] dir_vector,
    output logic              s_interruption,
    output logic              in_service,
    output logic [1:0]        active_id,
    output logic [NSRC-1:0]   irq_pending
);

    state_t            state_q;
    logic [2:0]        hist_q;
    logic [NSRC-1:0]   pend_q, pend_d, pend_set, pend_clr;
    logic [ADDR_W-1:0] dir_q, dir_d;
    logic [1:0]        id_q, prio_id;
    logic              strobe_q;
    logic              busy_q;
    logic              tick;
    logic              take;
    logic [2:0]        req;

`ifdef IRQ_TIMER_EN
    irq_timer #(
        .TIMER_PERIOD (TIMER_PERIOD),
        .TW           (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (timer_en),
        .tick  (tick)
    );
`else
    localparam int unused_timer_cfg = TIMER_PERIOD + TW;
    logic unused_timer_en;
    assign unused_timer_en = timer_en;
    assign tick            = 1'b0;
`endif

    assign req      = {i_port, i_syscall, i_except};
    assign pend_set = {tick, req & ~hist_q};

    always_comb begin
        prio_id = ID_TIMER;
        if (pend_q[ID_EXCEPT]) begin
            prio_id = ID_EXCEPT;
        end else if (pend_q[ID_SYSCALL]) begin
            prio_id = ID_SYSCALL;
        end else if (pend_q[ID_PORT]) begin
            prio_id = ID_PORT;
        end
    end

    assign take     = (state_q == IDLE) && ie && (pend_q != '0);
    assign pend_clr = take ? (NSRC'(1) << prio_id) : '0;
    // A new edge on the bit being taken survives: set is applied after clear.
    assign pend_d   = (pend_q & ~pend_clr) | pend_set;
    assign dir_d    = VEC_BASE + ADDR_W'(prio_id) * ADDR_W'(VEC_STRIDE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hist_q   <= '0;
            pend_q   <= '0;
            dir_q    <= '0;
            id_q     <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            hist_q   <= req;
            pend_q   <= pend_d;
            strobe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (take) begin
                        state_q  <= TAKE;
                        id_q     <= prio_id;
                        dir_q    <= dir_d;
                        strobe_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                TAKE: begin
                    state_q <= SERVICE;
                end
                SERVICE: begin
                    if (s_finished) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dir_vector     = dir_q;
    assign s_interruption = strobe_q;
    assign in_service     = busy_q;
    assign active_id      = id_q;
    assign irq_pending    = pend_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    irq_controller_if bus ();

    logic [9:0] dir2;
    logic       strobe2, busy2;
    logic [1:0] id2;
    logic [3:0] pend2;

    always #5 clk = ~clk;

    irq_controller #(.TIMER_PERIOD(4), .TW(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_except       (bus.i_except),
        .i_syscall      (bus.i_syscall),
        .i_port         (bus.i_port),
        .timer_en       (bus.timer_en),
        .ie             (bus.ie),
        .s_finished     (bus.s_finished),
        .dir_vector     (bus.dir_vector),
        .s_interruption (bus.s_interruption),
        .in_service     (bus.in_service),
        .active_id      (bus.active_id),
        .irq_pending    (bus.irq_pending)
    );

    irq_controller #(.VEC_BASE(10'h3F8), .TIMER_PERIOD(4), .TW(4)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .i_except       (bus.i_except),
        .i_syscall      (bus.i_syscall),
        .i_port         (bus.i_port),
        .timer_en       (bus.timer_en),
        .ie             (bus.ie),
        .s_finished     (bus.s_finished),
        .dir_vector     (dir2),
        .s_interruption (strobe2),
        .in_service     (busy2),
        .active_id      (id2),
        .irq_pending    (pend2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_handler();
        bus.s_finished = 1'b1;
        step();
        bus.s_finished = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_except = 0; bus.i_syscall = 0; bus.i_port = 0;
        bus.timer_en = 0; bus.ie = 0; bus.s_finished = 0;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (bus.dir_vector !== 10'h000) begin failures++; $display("FAIL reset_dir got=%h exp=000", bus.dir_vector); end
        checks++; if (bus.s_interruption !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", bus.s_interruption); end
        checks++; if (bus.in_service !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.in_service); end
        checks++; if (bus.active_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.active_id); end
        checks++; if (bus.irq_pending !== 4'b0000) begin failures++; $display("FAIL reset_pending got=%b exp=0000", bus.irq_pending); end
    endtask

    task automatic test_port_single();
        int n;
        bus.ie = 1'b1;
        bus.i_port = 1'b1;
        step();
        checks++; if (bus.irq_pending !== 4'b0100) begin failures++; $display("FAIL port_pending got=%b exp=0100", bus.irq_pending); end
        checks++; if (bus.s_interruption !== 1'b0) begin failures++; $display("FAIL port_early_strobe got=%b exp=0", bus.s_interruption); end
        step();
        checks++; if (bus.s_interruption !== 1'b1) begin failures++; $display("FAIL port_strobe got=%b exp=1", bus.s_interruption); end
        checks++; if (bus.dir_vector !== 10'h3E0) begin failures++; $display("FAIL port_dir got=%h exp=3e0", bus.dir_vector); end
        checks++; if (bus.active_id !== 2'd2) begin failures++; $display("FAIL port_id got=%0d exp=2", bus.active_id); end
        checks++; if (bus.irq_pending !== 4'b0000) begin failures++; $display("FAIL port_clear got=%b exp=0000", bus.irq_pending); end
        step();
        bus.i_port = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.s_interruption) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL port_held_retake got=%0d exp=0", n); end
        checks++; if (bus.in_service !== 1'b1) begin failures++; $display("FAIL port_busy got=%b exp=1", bus.in_service); end
        checks++; if (bus.dir_vector !== 10'h3E0) begin failures++; $display("FAIL port_dir_hold got=%h exp=3e0", bus.dir_vector); end
        finish_handler();
        checks++; if (bus.in_service !== 1'b0) begin failures++; $display("FAIL port_done got=%b exp=0", bus.in_service); end
        step();
        checks++; if (bus.s_interruption !== 1'b0) begin failures++; $display("FAIL port_idle_strobe got=%b exp=0", bus.s_interruption); end
    endtask

    task automatic test_priority();
        bus.i_except = 1'b1; bus.i_syscall = 1'b1; bus.i_port = 1'b1;
        step();
        bus.i_except = 1'b0; bus.i_syscall = 1'b0; bus.i_port = 1'b0;
        checks++; if (bus.irq_pending !== 4'b0111) begin failures++; $display("FAIL prio_pending got=%b exp=0111", bus.irq_pending); end
        step();
        checks++; if (bus.dir_vector !== 10'h3C0 || bus.active_id !== 2'd0) begin failures++; $display("FAIL prio_first got=%h/%0d exp=3c0/0", bus.dir_vector, bus.active_id); end
        checks++; if (bus.irq_pending !== 4'b0110) begin failures++; $display("FAIL prio_left got=%b exp=0110", bus.irq_pending); end
        checks++; if (dir2 !== 10'h3F8) begin failures++; $display("FAIL wrap_id0 got=%h exp=3f8", dir2); end
        step();
        finish_handler();
        checks++; if (bus.s_interruption !== 1'b0 || bus.in_service !== 1'b0) begin failures++; $display("FAIL prio_gap got=%b/%b exp=0/0", bus.s_interruption, bus.in_service); end
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3D0 || bus.active_id !== 2'd1) begin failures++; $display("FAIL prio_second got=%b/%h/%0d exp=1/3d0/1", bus.s_interruption, bus.dir_vector, bus.active_id); end
        checks++; if (dir2 !== 10'h008) begin failures++; $display("FAIL wrap_id1 got=%h exp=008", dir2); end
        step();
        finish_handler();
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3E0) begin failures++; $display("FAIL prio_third got=%b/%h exp=1/3e0", bus.s_interruption, bus.dir_vector); end
        checks++; if (dir2 !== 10'h018) begin failures++; $display("FAIL wrap_id2 got=%h exp=018", dir2); end
        step();
        finish_handler();
        step();
    endtask

    task automatic test_ie_gating();
        int n;
        bus.ie = 1'b0;
        bus.i_syscall = 1'b1; bus.i_port = 1'b1;
        step();
        bus.i_syscall = 1'b0; bus.i_port = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.s_interruption) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL ie0_strobes got=%0d exp=0", n); end
        checks++; if (bus.irq_pending !== 4'b0110) begin failures++; $display("FAIL ie0_pending got=%b exp=0110", bus.irq_pending); end
        bus.ie = 1'b1;
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3D0) begin failures++; $display("FAIL ie1_syscall got=%b/%h exp=1/3d0", bus.s_interruption, bus.dir_vector); end
        step();
        bus.ie = 1'b0;
        step();
        checks++; if (bus.in_service !== 1'b1) begin failures++; $display("FAIL ie_drop_abort got=%b exp=1", bus.in_service); end
        bus.ie = 1'b1;
        finish_handler();
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3E0 || bus.active_id !== 2'd2) begin failures++; $display("FAIL ie1_port got=%b/%h/%0d exp=1/3e0/2", bus.s_interruption, bus.dir_vector, bus.active_id); end
        step();
        finish_handler();
        step();
    endtask

    task automatic test_no_preempt();
        bus.i_port = 1'b1;
        step();
        bus.i_port = 1'b0;
        step();
        checks++; if (bus.s_interruption !== 1'b1) begin failures++; $display("FAIL np_take got=%b exp=1", bus.s_interruption); end
        bus.s_finished = 1'b1;
        step();
        bus.s_finished = 1'b0;
        step();
        checks++; if (bus.in_service !== 1'b1) begin failures++; $display("FAIL np_fin_in_take got=%b exp=1", bus.in_service); end
        bus.i_except = 1'b1;
        step();
        bus.i_except = 1'b0;
        step(); step();
        checks++; if (bus.in_service !== 1'b1 || bus.s_interruption !== 1'b0 || bus.active_id !== 2'd2) begin failures++; $display("FAIL np_preempt got=%b/%b/%0d exp=1/0/2", bus.in_service, bus.s_interruption, bus.active_id); end
        checks++; if (bus.irq_pending !== 4'b0001) begin failures++; $display("FAIL np_pending got=%b exp=0001", bus.irq_pending); end
        finish_handler();
        checks++; if (bus.s_interruption !== 1'b0) begin failures++; $display("FAIL np_gap got=%b exp=0", bus.s_interruption); end
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3C0) begin failures++; $display("FAIL np_except got=%b/%h exp=1/3c0", bus.s_interruption, bus.dir_vector); end
        step();
        finish_handler();
        step();
    endtask

`ifdef IRQ_TIMER_EN
    task automatic test_timer();
        int n;
        bus.ie = 1'b0;
        bus.timer_en = 1'b1;
        n = 0;
        while (bus.irq_pending[3] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL timer_first got=%0d exp=4", n); end
        bus.ie = 1'b1;
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3F0 || bus.active_id !== 2'd3) begin failures++; $display("FAIL timer_take got=%b/%h/%0d exp=1/3f0/3", bus.s_interruption, bus.dir_vector, bus.active_id); end
        n = 0;
        while (bus.irq_pending[3] !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++; if (n !== 3) begin failures++; $display("FAIL timer_period got=%0d exp=3", n); end
        bus.timer_en = 1'b0;
        step();
        finish_handler();
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.active_id !== 2'd3) begin failures++; $display("FAIL timer_b2b got=%b/%0d exp=1/3", bus.s_interruption, bus.active_id); end
        step();
        finish_handler();
        step();
    endtask
`else
    task automatic test_timer();
        int n;
        bus.ie = 1'b1;
        bus.timer_en = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.irq_pending[3] || bus.s_interruption) n++;
        end
        bus.timer_en = 1'b0;
        checks++; if (n !== 0) begin failures++; $display("FAIL timer_off got=%0d exp=0", n); end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        bus.ie = 1'b1;
        bus.i_port = 1'b1;
        step();
        bus.i_port = 1'b0;
        step(); step();
        bus.i_except = 1'b1; bus.i_syscall = 1'b1;
        step();
        bus.i_except = 1'b0; bus.i_syscall = 1'b0;
        checks++; if (bus.irq_pending !== 4'b0011 || bus.in_service !== 1'b1) begin failures++; $display("FAIL rm_setup got=%b/%b exp=0011/1", bus.irq_pending, bus.in_service); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.irq_pending !== 4'b0000 || bus.in_service !== 1'b0 || bus.s_interruption !== 1'b0) begin failures++; $display("FAIL rm_clear got=%b/%b/%b exp=0000/0/0", bus.irq_pending, bus.in_service, bus.s_interruption); end
        checks++; if (bus.dir_vector !== 10'h000 || bus.active_id !== 2'd0) begin failures++; $display("FAIL rm_outs got=%h/%0d exp=000/0", bus.dir_vector, bus.active_id); end
        n = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.s_interruption) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL rm_no_take got=%0d exp=0", n); end
        bus.i_except = 1'b1;
        step();
        bus.i_except = 1'b0;
        step();
        checks++; if (bus.s_interruption !== 1'b1 || bus.dir_vector !== 10'h3C0) begin failures++; $display("FAIL rm_new_edge got=%b/%h exp=1/3c0", bus.s_interruption, bus.dir_vector); end
        step();
        finish_handler();
        step();
    endtask

    initial begin
        test_reset();
        test_port_single();
        test_priority();
        test_ie_gating();
        test_no_preempt();
        test_timer();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
